// File: rtl/vga_sync_gen.sv
// VGA raster timing: horizontal/vertical phase FSMs, column/row counters and registered syncs.
// Optional 8-bit frame counter output when VGA_SYNC_FRAME_CNT_EN is defined.
module vga_sync_gen #(
  parameter int c_ACTIVE_COLS     = 640,
  parameter int c_H_FRONT_PORCH   = 16,
  parameter int c_H_SYNC_WIDTH    = 96,
  parameter int c_H_BACK_PORCH    = 48,
  parameter int c_ACTIVE_ROWS     = 480,
  parameter int c_V_FRONT_PORCH   = 10,
  parameter int c_V_SYNC_WIDTH    = 2,
  parameter int c_V_BACK_PORCH    = 33,
  parameter int c_SYNC_ACTIVE_LOW = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Pix_En,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Active,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0] o_Frame_Count
`endif
);

  localparam int c_TOTAL_COLS = c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH + c_H_BACK_PORCH;
  localparam int c_TOTAL_ROWS = c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH + c_V_BACK_PORCH;

  localparam logic [9:0] c_H_ACT_END  = 10'(c_ACTIVE_COLS);
  localparam logic [9:0] c_H_SYNC_BEG = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH);
  localparam logic [9:0] c_H_SYNC_END = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH);
  localparam logic [9:0] c_COL_LAST   = 10'(c_TOTAL_COLS - 1);
  localparam logic [9:0] c_V_ACT_END  = 10'(c_ACTIVE_ROWS);
  localparam logic [9:0] c_V_SYNC_BEG = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH);
  localparam logic [9:0] c_V_SYNC_END = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH);
  localparam logic [9:0] c_ROW_LAST   = 10'(c_TOTAL_ROWS - 1);
  localparam logic       c_SYNC_OFF   = (c_SYNC_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNC, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNC, V_BACK} v_state_t;

  h_state_t   h_state, h_nxt;
  v_state_t   v_state, v_nxt;
  logic [9:0] col_nxt, row_nxt;
  logic       col_wrap, frame_wrap;

  always_comb begin
    col_nxt    = o_Col_Count;
    row_nxt    = o_Row_Count;
    h_nxt      = h_state;
    v_nxt      = v_state;
    col_wrap   = 1'b0;
    frame_wrap = 1'b0;

    if (i_Pix_En) begin
      if (o_Col_Count == c_COL_LAST) begin
        col_nxt  = '0;
        col_wrap = 1'b1;
      end else begin
        col_nxt = o_Col_Count + 10'd1;
      end
      if (col_wrap) begin
        if (o_Row_Count == c_ROW_LAST) begin
          row_nxt    = '0;
          frame_wrap = 1'b1;
        end else begin
          row_nxt = o_Row_Count + 10'd1;
        end
      end

      // Phase changes are keyed on the column/row being entered, so state and count stay in step.
      unique case (h_state)
        H_ACTIVE: if (col_nxt == c_H_ACT_END)  h_nxt = H_FRONT;
        H_FRONT:  if (col_nxt == c_H_SYNC_BEG) h_nxt = H_SYNC;
        H_SYNC:   if (col_nxt == c_H_SYNC_END) h_nxt = H_BACK;
        H_BACK:   if (col_nxt == '0)           h_nxt = H_ACTIVE;
        default:                               h_nxt = H_ACTIVE;
      endcase

      if (col_wrap) begin
        unique case (v_state)
          V_ACTIVE: if (row_nxt == c_V_ACT_END)  v_nxt = V_FRONT;
          V_FRONT:  if (row_nxt == c_V_SYNC_BEG) v_nxt = V_SYNC;
          V_SYNC:   if (row_nxt == c_V_SYNC_END) v_nxt = V_BACK;
          V_BACK:   if (row_nxt == '0)           v_nxt = V_ACTIVE;
          default:                               v_nxt = V_ACTIVE;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      h_state       <= H_ACTIVE;
      v_state       <= V_ACTIVE;
      o_Col_Count   <= '0;
      o_Row_Count   <= '0;
      o_Active      <= 1'b1;
      o_HSync       <= c_SYNC_OFF;
      o_VSync       <= c_SYNC_OFF;
      o_Frame_Start <= 1'b0;
    end else begin
      // Outputs decode the next-state values so every output describes the same pixel.
      h_state       <= h_nxt;
      v_state       <= v_nxt;
      o_Col_Count   <= col_nxt;
      o_Row_Count   <= row_nxt;
      o_Active      <= (col_nxt < c_H_ACT_END) && (row_nxt < c_V_ACT_END);
      o_HSync       <= (h_nxt == H_SYNC) ? ~c_SYNC_OFF : c_SYNC_OFF;
      o_VSync       <= (v_nxt == V_SYNC) ? ~c_SYNC_OFF : c_SYNC_OFF;
      o_Frame_Start <= frame_wrap;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n)        o_Frame_Count <= '0;
    else if (frame_wrap) o_Frame_Count <= o_Frame_Count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: small-raster instances (both polarities) against an arithmetic
// raster model, plus a default-parameter instance for the 640x480 line timing.
module tb_vga_sync_gen;
  localparam int AC = 12, HFP = 2, HSW = 3, HBP = 2;
  localparam int AR = 6,  VFP = 1, VSW = 1, VBP = 1;
  localparam int TC = AC + HFP + HSW + HBP;
  localparam int TR = AR + VFP + VSW + VBP;
  localparam int TF = TC * TR;

  logic clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0;
  always #5 clk = ~clk;

  logic       lo_hs, lo_vs, lo_act, lo_fs, hi_hs, hi_vs, hi_act, hi_fs, def_hs, def_vs, def_act, def_fs;
  logic [9:0] lo_col, lo_row, hi_col, hi_row, def_col, def_row;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] lo_fc, hi_fc, def_fc;
`endif

  vga_sync_gen #(.c_ACTIVE_COLS(AC), .c_H_FRONT_PORCH(HFP), .c_H_SYNC_WIDTH(HSW), .c_H_BACK_PORCH(HBP),
    .c_ACTIVE_ROWS(AR), .c_V_FRONT_PORCH(VFP), .c_V_SYNC_WIDTH(VSW), .c_V_BACK_PORCH(VBP),
    .c_SYNC_ACTIVE_LOW(1)) u_lo (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Pix_En(pix_en), .o_HSync(lo_hs), .o_VSync(lo_vs),
    .o_Active(lo_act), .o_Col_Count(lo_col), .o_Row_Count(lo_row), .o_Frame_Start(lo_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .o_Frame_Count(lo_fc)
`endif
  );

  vga_sync_gen #(.c_ACTIVE_COLS(AC), .c_H_FRONT_PORCH(HFP), .c_H_SYNC_WIDTH(HSW), .c_H_BACK_PORCH(HBP),
    .c_ACTIVE_ROWS(AR), .c_V_FRONT_PORCH(VFP), .c_V_SYNC_WIDTH(VSW), .c_V_BACK_PORCH(VBP),
    .c_SYNC_ACTIVE_LOW(0)) u_hi (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Pix_En(pix_en), .o_HSync(hi_hs), .o_VSync(hi_vs),
    .o_Active(hi_act), .o_Col_Count(hi_col), .o_Row_Count(hi_row), .o_Frame_Start(hi_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .o_Frame_Count(hi_fc)
`endif
  );

  vga_sync_gen u_def (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Pix_En(pix_en), .o_HSync(def_hs), .o_VSync(def_vs),
    .o_Active(def_act), .o_Col_Count(def_col), .o_Row_Count(def_row), .o_Frame_Start(def_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .o_Frame_Count(def_fc)
`endif
  );

  logic [23:0] obs_lo, obs_hi, obs_def;
  assign obs_lo  = {lo_hs, lo_vs, lo_act, lo_col, lo_row, lo_fs};
  assign obs_hi  = {hi_hs, hi_vs, hi_act, hi_col, hi_row, hi_fs};
  assign obs_def = {def_hs, def_vs, def_act, def_col, def_row, def_fs};

  int vecs = 0, errs = 0;
  int m_col = 0, m_row = 0, m_fc = 0;
  bit m_fs = 1'b0;

  // Expected outputs straight from the raster position: sync windows and active area by range.
  function automatic logic [23:0] exp_vec(bit act_low);
    bit hs_on, vs_on, act;
    hs_on = (m_col >= AC + HFP) && (m_col < AC + HFP + HSW);
    vs_on = (m_row >= AR + VFP) && (m_row < AR + VFP + VSW);
    act   = (m_col < AC) && (m_row < AR);
    return {act_low ? !hs_on : hs_on, act_low ? !vs_on : vs_on, act, 10'(m_col), 10'(m_row), m_fs};
  endfunction

  task automatic step(input bit rst, input bit en);
    @(negedge clk);
    rst_n  = rst;
    pix_en = en;
    @(posedge clk);
    #1;
    if (!rst) begin
      m_col = 0; m_row = 0; m_fs = 1'b0; m_fc = 0;
    end else if (en) begin
      m_fs  = 1'b0;
      m_col = m_col + 1;
      if (m_col == TC) begin
        m_col = 0;
        m_row = m_row + 1;
        if (m_row == TR) begin
          m_row = 0; m_fs = 1'b1; m_fc = (m_fc + 1) % 256;
        end
      end
    end else begin
      m_fs = 1'b0;
    end
  endtask

  task automatic test_reset();
    step(0, 1);
    step(0, 1);
    vecs++;
    if (obs_lo !== 24'h e00000) begin
      errs++; $display("FAIL reset_lo got %h want %h", obs_lo, 24'he00000);
    end
    vecs++;
    if (obs_hi !== 24'h 200000) begin
      errs++; $display("FAIL reset_hi got %h want %h", obs_hi, 24'h200000);
    end
    vecs++;
    if (obs_def !== 24'h e00000) begin
      errs++; $display("FAIL reset_def got %h want %h", obs_def, 24'he00000);
    end
`ifdef VGA_SYNC_FRAME_CNT_EN
    vecs++;
    if (lo_fc !== 8'd0) begin
      errs++; $display("FAIL reset_fcnt got %0d want 0", lo_fc);
    end
`endif
  endtask

  task automatic test_default_line();
    int first_low = -1, rise = -1, low_cnt = 0, act_cnt = 0;
    bit prev_low = 1'b0;
    for (int i = 0; i < 800; i++) begin
      step(1, 1);
      if (!def_hs) begin
        low_cnt++;
        if (first_low < 0) first_low = int'(def_col);
      end else if (prev_low && rise < 0) begin
        rise = int'(def_col);
      end
      prev_low = !def_hs;
      if (def_act) act_cnt++;
    end
    vecs++;
    if (first_low != 656) begin errs++; $display("FAIL def_hsync_fall col got %0d want 656", first_low); end
    vecs++;
    if (rise != 752) begin errs++; $display("FAIL def_hsync_rise col got %0d want 752", rise); end
    vecs++;
    if (low_cnt != 96) begin errs++; $display("FAIL def_hsync_width got %0d want 96", low_cnt); end
    vecs++;
    if (act_cnt != 640) begin errs++; $display("FAIL def_active_count got %0d want 640", act_cnt); end
    vecs++;
    if ({def_col, def_row, def_vs, def_fs} !== {10'd0, 10'd1, 1'b1, 1'b0}) begin
      errs++; $display("FAIL def_line_end got col %0d row %0d vs %b fs %b want 0 1 1 0",
                       def_col, def_row, def_vs, def_fs);
    end
  endtask

  task automatic test_random(input int n);
    int duty;
    for (int i = 0; i < n; i++) begin
      if (i % 200 == 0) duty = $urandom_range(10, 100);
      step($urandom_range(0, 299) != 0, $urandom_range(1, 100) <= duty);
      vecs++;
      if (obs_lo !== exp_vec(1)) begin
        errs++; if (errs < 30) $display("FAIL rand_lo got %h want %h", obs_lo, exp_vec(1));
      end
      vecs++;
      if (obs_hi !== exp_vec(0)) begin
        errs++; if (errs < 30) $display("FAIL rand_hi got %h want %h", obs_hi, exp_vec(0));
      end
`ifdef VGA_SYNC_FRAME_CNT_EN
      vecs++;
      if (lo_fc !== 8'(m_fc)) begin
        errs++; if (errs < 30) $display("FAIL rand_fcnt got %0d want %0d", lo_fc, m_fc);
      end
`endif
    end
  endtask

  task automatic test_half_duty();
    int low_cnt = 0;
    step(0, 1);
    for (int i = 0; i < 2 * TC; i++) begin
      step(1, (i % 2) == 0);
      if (!lo_hs) low_cnt++;
      vecs++;
      if (obs_lo !== exp_vec(1)) begin
        errs++; if (errs < 30) $display("FAIL half_lo got %h want %h", obs_lo, exp_vec(1));
      end
      vecs++;
      if (obs_hi !== exp_vec(0)) begin
        errs++; if (errs < 30) $display("FAIL half_hi got %h want %h", obs_hi, exp_vec(0));
      end
    end
    vecs++;
    if (low_cnt != 2 * HSW) begin errs++; $display("FAIL half_hsync_width got %0d want %0d", low_cnt, 2 * HSW); end
    vecs++;
    if ({lo_col, lo_row} !== {10'd0, 10'd1}) begin
      errs++; $display("FAIL half_line_period got col %0d row %0d want 0 1", lo_col, lo_row);
    end
  endtask

  task automatic test_mid_reset();
    step(0, 1);
    // Park inside both sync windows, then a single reset cycle.
    for (int i = 0; i < (AR + VFP) * TC + AC + HFP + 1; i++) step(1, 1);
    vecs++;
    if ({lo_hs, lo_vs} !== 2'b00) begin errs++; $display("FAIL mid_pre_sync got %b want 00", {lo_hs, lo_vs}); end
    step(0, 1);
    vecs++;
    if (obs_lo !== 24'he00000) begin errs++; $display("FAIL mid_reset_lo got %h want %h", obs_lo, 24'he00000); end
    vecs++;
    if (obs_hi !== 24'h200000) begin errs++; $display("FAIL mid_reset_hi got %h want %h", obs_hi, 24'h200000); end
    step(1, 1);
    vecs++;
    if (obs_lo !== exp_vec(1)) begin errs++; $display("FAIL mid_after_lo got %h want %h", obs_lo, exp_vec(1)); end
  endtask

  task automatic test_frame_start();
    int pulses = 0;
    step(0, 1);
    for (int i = 1; i <= 257 * TF; i++) begin
      step(1, 1);
      if (lo_fs) pulses++;
      vecs++;
      if (lo_fs !== ((i % TF) == 0) || obs_lo !== exp_vec(1)) begin
        errs++; if (errs < 30) $display("FAIL frame_lo tick %0d got %h want %h", i, obs_lo, exp_vec(1));
      end
`ifdef VGA_SYNC_FRAME_CNT_EN
      if ((i % TF) == 0) begin
        vecs++;
        if (lo_fc !== 8'((i / TF) % 256) || hi_fc !== lo_fc) begin
          errs++; if (errs < 30) $display("FAIL frame_count tick %0d got %0d want %0d", i, lo_fc, (i / TF) % 256);
        end
      end
`endif
    end
    vecs++;
    if (pulses != 257) begin errs++; $display("FAIL frame_pulses got %0d want 257", pulses); end
  endtask

  initial begin
    test_reset();
    test_default_line();
    test_random(4000);
    test_half_duty();
    test_mid_reset();
    test_frame_start();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates the VGA timing that the Frogg game top consumes. It produces the horizontal and vertical sync pulses, an active-video flag, and registered column/row counts for the 640x480@60 raster. The block drives the i_HSync/i_VSync inputs of the game core and the display connector. Porch and sync widths are parameters, and every output is registered and aligned to the same pixel.

## Interface
- c_ACTIVE_COLS, 640, visible pixels per line
- c_H_FRONT_PORCH, 16, pixels after active video before HSync
- c_H_SYNC_WIDTH, 96, HSync pulse width in pixels
- c_H_BACK_PORCH, 48, pixels after HSync
- c_ACTIVE_ROWS, 480, visible lines per frame
- c_V_FRONT_PORCH, 10, lines after active video before VSync
- c_V_SYNC_WIDTH, 2, VSync pulse width in lines
- c_V_BACK_PORCH, 33, lines after VSync
- c_SYNC_ACTIVE_LOW, 1, 1 means sync is asserted as 0, 0 means sync is asserted as 1
- Derived values, not overridable:
  - c_TOTAL_COLS is the sum of the four horizontal parameters (800).
  - c_TOTAL_ROWS is the sum of the four vertical parameters (525).

Ports:
- i_Clk, in, 1, pixel-domain clock
- i_Rst_n, in, 1, synchronous active-low reset, sampled on the rising edge of i_Clk
- i_Pix_En, in, 1, pixel tick; the raster advances one pixel per clock in which it is 1 (tie to 1 at 25 MHz)
- o_HSync, out, 1, horizontal sync at the configured polarity
- o_VSync, out, 1, vertical sync at the configured polarity
- o_Active, out, 1, 1 while (col < c_ACTIVE_COLS) and (row < c_ACTIVE_ROWS)
- o_Col_Count, out, 10, current column, 0 to c_TOTAL_COLS-1
- o_Row_Count, out, 10, current row, 0 to c_TOTAL_ROWS-1
- o_Frame_Start, out, 1, one-clock pulse on the clock in which the counters wrap to (0,0)

## Operation
- The horizontal phase FSM has four states: H_ACTIVE, H_FRONT, H_SYNC, H_BACK.
  - Transitions occur on a pixel tick when the column moves to c_ACTIVE_COLS, then to +FP, then to +FP+SYNC, then wraps to 0.
  - With default parameters the transition columns are 640, 656, 752 and 0.
- The vertical phase FSM has the same four states (V_ACTIVE, V_FRONT, V_SYNC, V_BACK).
  - It advances only on a pixel tick in which the column wraps from c_TOTAL_COLS-1 to 0.
  - With default parameters the row transitions are 480, 490, 492 and 0.
- Column counting: increments on each tick and wraps from c_TOTAL_COLS-1 to 0.
- Row counting: increments only on a column wrap, and wraps from c_TOTAL_ROWS-1 to 0.
- HSync is asserted exactly while the horizontal state is H_SYNC; VSync is asserted exactly while the vertical state is V_SYNC.
- Both FSMs and both counters are updated on the same edge. All outputs are therefore decoded from the next-state values, so the outputs always describe the same pixel.
- When i_Pix_En is 0, all outputs hold their values, and o_Frame_Start is 0.
- The block has no other inputs; a parameter set whose sums exceed 1023 is illegal.

## Timing
- Reset values, set on the first rising edge with i_Rst_n=0:
  - counters are 0 and both FSMs are in their ACTIVE state
  - o_Active=1
  - o_HSync and o_VSync are deasserted (1 when c_SYNC_ACTIVE_LOW=1)
  - o_Frame_Start=0
- Reset mid-frame abandons the current frame immediately. No o_Frame_Start is issued for the forced return to (0,0).
- Latency: output changes land on the same edge as the pixel tick that causes them; there is no extra pipeline stage.
- Per-line timing with i_Pix_En tied to 1:
  - HSync is asserted for 96 consecutive clocks per 800-clock line.
  - o_Active is high for 640 clocks per line on the 480 active rows.
- Per-frame timing: VSync is asserted for 2×800 = 1600 consecutive clocks per 420000-clock frame.
- o_Frame_Start is high for exactly one clock: the clock in which the counters read (0,0) after a wrap from (799,524).

## Configuration
- Macro: VGA_SYNC_FRAME_CNT_EN.
- Defined:
  - Adds the output o_Frame_Count (8 bits, reset value 0).
  - o_Frame_Count increments on the same edge on which o_Frame_Start is asserted and wraps from 255 to 0.
  - Used by the game for animation timing.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset release, i_Pix_En=1 → col=0, row=0, o_Active=1 and both syncs=1 for the first clock; at col=656 HSync falls; at col=752 HSync rises.
- Run one full frame → o_Frame_Start is seen exactly once, 420000 clocks after the first wrap. VSync is low for rows 490 and 491 only; o_Active=0 for every col ≥640 and every row ≥480.
- i_Pix_En toggled 1,0,1,0 (50% duty) → each count is held for 2 clocks; HSync low for 192 clocks; line period 1600 clocks.
- i_Rst_n pulsed low for 1 clock at (700,300) → next edge shows (0,0), o_Active=1, syncs deasserted and o_Frame_Start=0.
- c_SYNC_ACTIVE_LOW=0 → HSync is 1 for cols 656–751 and 0 elsewhere; reset value of both syncs is 0.
- VGA_SYNC_FRAME_CNT_EN defined, run 257 frames → o_Frame_Count goes 1,2,…,255,0,1, each step coincident with o_Frame_Start.
